// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: data-memory access sequencer for two requesters.
// m0 is the CPU load/store stage and m1 is the debug/loader port. One
// transaction is in flight at a time. Byte and halfword stores become a
// word read followed by a merged word write. Loads return sign- or
// zero-extended data together with a one-cycle ack.
// Optional build macro DMEM_ACCESS_CTRL_RR_EN selects round-robin
// arbitration. Without it, m0 has fixed priority over m1.
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [1:0]        m0_size,
  input  logic              m0_uns,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [1:0]        m1_size,
  input  logic              m1_uns,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

  state_t            state, state_nxt;
  logic              cur_m, cur_wr, cur_uns, cur_err;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata, rdata_q, merge_q;

  logic              sel1, accept, win_wr, win_uns, win_bad;
  logic [1:0]        win_size;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              sub_word, done;
  logic [DATA_W-1:0] rdata_out;

  // Misaligned halfword/word or reserved size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b11) || (size == 2'b01 && off[0]) ||
           (size == 2'b10 && off != 2'b00);
  endfunction

  // Select the addressed little-endian lane and extend it to a full word.
  function automatic logic [DATA_W-1:0] extract_lane(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [1:0] size,
                                                     input logic uns);
    logic [DATA_W-1:0]        sh;
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] ext;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   ext = uns ? $signed({{(DATA_W-8){1'b0}}, sh[7:0]}) : b;
      2'b01:   ext = uns ? $signed({{(DATA_W-16){1'b0}}, sh[15:0]}) : h;
      default: ext = $signed(word);
    endcase
    return $unsigned(ext);
  endfunction

  // Replace the addressed byte/half lane of the previously read word.
  function automatic logic [DATA_W-1:0] merge_lane(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] wd,
                                                   input logic [1:0] off,
                                                   input logic [1:0] size);
    logic [DATA_W-1:0] mask;
    mask = (size == 2'b00) ? {{(DATA_W-8){1'b0}}, 8'hFF}
                           : {{(DATA_W-16){1'b0}}, 16'hFFFF};
    mask = mask << {off, 3'b000};
    return (old & ~mask) | ((wd << {off, 3'b000}) & mask);
  endfunction

`ifdef DMEM_ACCESS_CTRL_RR_EN
  logic last_q;

  // Last-grant pointer: on contention the master not granted last wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         last_q <= 1'b1;
    else if (accept) last_q <= sel1;
  end

  // Round-robin winner select.
  always_comb sel1 = m1_req && (!m0_req || !last_q);
`else
  // Fixed priority winner select: m0 always wins.
  always_comb sel1 = m1_req && !m0_req;
`endif

  // Winner request fields and acceptance.
  always_comb begin
    accept    = (state == IDLE) && (m0_req || m1_req);
    win_wr    = sel1 ? m1_wr    : m0_wr;
    win_size  = sel1 ? m1_size  : m0_size;
    win_uns   = sel1 ? m1_uns   : m0_uns;
    win_addr  = sel1 ? m1_addr  : m0_addr;
    win_wdata = sel1 ? m1_wdata : m0_wdata;
    win_bad   = misaligned(win_size, win_addr[1:0]);
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latched transaction plus load-result and merge capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_m     <= 1'b0;
      cur_wr    <= 1'b0;
      cur_size  <= 2'b00;
      cur_uns   <= 1'b0;
      cur_err   <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      rdata_q   <= '0;
      merge_q   <= '0;
    end else if (accept) begin
      cur_m     <= sel1;
      cur_wr    <= win_wr;
      cur_size  <= win_size;
      cur_uns   <= win_uns;
      cur_err   <= win_bad;
      cur_addr  <= win_addr;
      cur_wdata <= win_wdata;
      rdata_q   <= '0;
    end else if (state == ACCESS) begin
      if (!cur_wr)        rdata_q <= extract_lane(mem_rdata, cur_addr[1:0], cur_size, cur_uns);
      else if (sub_word)  merge_q <= mem_rdata;
    end
  end

  // Next state, arbitration strobes, memory controls and completion outputs.
  always_comb begin
    state_nxt = state;
    sub_word  = (cur_size != 2'b10);
    done      = (state == DONE);
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        m0_ready = m0_req && !sel1;
        m1_ready = sel1;
        if (accept) state_nxt = win_bad ? DONE : ACCESS;
      end
      ACCESS: begin
        mem_addr = {cur_addr[ADDR_W-1:2], 2'b00};
        if (cur_wr && !sub_word) begin
          mem_we    = 1'b1;
          mem_wdata = cur_wdata;
          state_nxt = DONE;
        end else begin
          mem_re    = 1'b1;
          state_nxt = (cur_wr) ? MERGE : DONE;
        end
      end
      MERGE: begin
        mem_addr  = {cur_addr[ADDR_W-1:2], 2'b00};
        mem_we    = 1'b1;
        mem_wdata = merge_lane(merge_q, cur_wdata, cur_addr[1:0], cur_size);
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    rdata_out = (done && !cur_wr && !cur_err) ? rdata_q : '0;
    m0_ack    = done && !cur_m;
    m1_ack    = done && cur_m;
    m0_err    = done && !cur_m && cur_err;
    m1_err    = done && cur_m && cur_err;
    m0_rdata  = cur_m ? '0 : rdata_out;
    m1_rdata  = cur_m ? rdata_out : '0;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and randomized checks of dmem_access_ctrl
// against a transaction-level model with its own memory image.
module tb_dmem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        m0_req, m0_wr, m0_uns, m1_req, m1_wr, m1_uns;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m0_ack, m0_err, m1_ready, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 CLK = ~CLK;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_uns(m0_uns),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ready(m0_ready),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_uns(m1_uns),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ready(m1_ready),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // 128-word memory behind the controller
  logic [31:0] mem [0:127] = '{default: 32'h0};
  assign mem_rdata = mem_re ? mem[mem_addr[8:2]] : 32'h0;
  always @(posedge CLK) if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit mdl_bad(input logic [31:0] a, input logic [1:0] s);
    return (s == 3) || (s == 1 && a[0]) || (s == 2 && a[1:0] != 0);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] s, input logic u);
    logic [31:0] v;
    v = w >> (a[1:0] * 8);
    if (s == 0) begin v = v & 32'hFF;   if (!u && v[7])  v = v | 32'hFFFFFF00; end
    if (s == 1) begin v = v & 32'hFFFF; if (!u && v[15]) v = v | 32'hFFFF0000; end
    return v;
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] s, input logic [31:0] d);
    logic [31:0] m;
    if (s == 2) return d;
    m = ((s == 0) ? 32'hFF : 32'hFFFF) << (a[1:0] * 8);
    return (w & ~m) | ((d << (a[1:0] * 8)) & m);
  endfunction

  logic [31:0] exp_mem [0:127] = '{default: 32'h0};
  bit          pend = 0, pwr, pbad, last_g = 1;
  int          pm, acc_cyc, due, cyc = 0, re_cnt, we_cnt;
  logic [1:0]  psize;
  logic [31:0] paddr, prdata, pnew;
  bit          acc_flag [2];
  int          done_cnt [2] = '{0, 0};
  logic [31:0] last_rdata [2];
  bit          last_err [2];
  int          last_lat [2];
  int          grants [$];

  // Compare process: model and DUT checked every cycle on the falling edge.
  always @(negedge CLK) begin
    bit exp_rdy1, exp_re, exp_we, a0, a1;
    int off, m;
    logic [31:0] ad; logic [1:0] sz; logic w, u;
    cyc++;
    acc_flag[0] = 0; acc_flag[1] = 0;
    if (RST) begin
      chk("reset_ctrl", {m0_ready, m1_ready, m0_ack, m1_ack, m0_err, m1_err, mem_re, mem_we}, 0);
      chk("reset_rdata", m0_rdata | m1_rdata, 0);
      chk("reset_mem_bus", mem_addr | mem_wdata, 0);
      pend = 0; last_g = 1;
    end else begin
`ifdef DMEM_ACCESS_CTRL_RR_EN
      exp_rdy1 = m1_req && (!m0_req || last_g == 0);
`else
      exp_rdy1 = m1_req && !m0_req;
`endif
      chk("m0_ready", m0_ready, !pend && m0_req && !exp_rdy1);
      chk("m1_ready", m1_ready, !pend && exp_rdy1);
      off = cyc - acc_cyc;
      a0 = pend && cyc == due && pm == 0;
      a1 = pend && cyc == due && pm == 1;
      chk("m0_ack", m0_ack, a0);
      chk("m1_ack", m1_ack, a1);
      chk("m0_err", m0_err, a0 && pbad);
      chk("m1_err", m1_err, a1 && pbad);
      chk("m0_rdata", m0_rdata, a0 ? prdata : 0);
      chk("m1_rdata", m1_rdata, a1 ? prdata : 0);
      exp_re = pend && !pbad && off == 1 && (!pwr || psize != 2);
      exp_we = pend && !pbad && pwr && ((off == 1 && psize == 2) || (off == 2 && psize != 2));
      chk("mem_re", mem_re, exp_re);
      chk("mem_we", mem_we, exp_we);
      if (exp_re || exp_we) chk("mem_addr", mem_addr, {paddr[31:2], 2'b00});
      if (exp_we) chk("mem_wdata", mem_wdata, pnew);
      if (mem_re) re_cnt++;
      if (mem_we) we_cnt++;
      if (pend && cyc == due) begin
        done_cnt[pm]++;
        last_rdata[pm] = pm ? m1_rdata : m0_rdata;
        last_err[pm]   = pm ? m1_err : m0_err;
        last_lat[pm]   = due - acc_cyc;
        if (pwr && !pbad) exp_mem[paddr[8:2]] = pnew;
        pend = 0;
      end
      if ((m0_req && m0_ready) || (m1_req && m1_ready)) begin
        m  = (m0_req && m0_ready) ? 0 : 1;
        ad = m ? m1_addr : m0_addr;
        sz = m ? m1_size : m0_size;
        w  = m ? m1_wr : m0_wr;
        u  = m ? m1_uns : m0_uns;
        acc_flag[m] = 1;
        grants.push_back(m);
        last_g  = m[0];
        pend    = 1; pm = m; pwr = w; psize = sz; paddr = ad;
        pbad    = mdl_bad(ad, sz);
        acc_cyc = cyc;
        due     = cyc + (pbad ? 1 : (w && sz != 2) ? 3 : 2);
        prdata  = (pbad || w) ? 0 : mdl_load(exp_mem[ad[8:2]], ad, sz, u);
        pnew    = mdl_store(exp_mem[ad[8:2]], ad, sz, m ? m1_wdata : m0_wdata);
        re_cnt  = 0; we_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_master(input int m, input logic rq, input logic w, input logic [1:0] s,
                            input logic u, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin m0_req = rq; m0_wr = w; m0_size = s; m0_uns = u; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = rq; m1_wr = w; m1_size = s; m1_uns = u; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) m0_req = 0; else m1_req = 0;
  endtask

  // Present a request and wait (bounded) for the accept edge.
  task automatic issue(input int m, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input bit hold);
    int guard = 0;
    set_master(m, 1, w, s, u, a, d);
    do begin @(posedge CLK); #1; guard++; end while (!acc_flag[m] && guard < 500);
    if (!acc_flag[m]) begin
      vectors++; miscompares++;
      $display("FAIL accept_m%0d: not accepted after %0d cycles, required accept", m, guard);
    end
    if (!hold) drop_req(m);
  endtask

  task automatic do_txn(input int m, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    int c = done_cnt[m];
    int guard = 0;
    issue(m, w, s, u, a, d, 0);
    while (done_cnt[m] == c && guard < 20) begin @(posedge CLK); #1; guard++; end
    if (done_cnt[m] == c) begin
      vectors++; miscompares++;
      $display("FAIL ack_m%0d: no ack within %0d cycles, required ack", m, guard);
    end
  endtask

  task automatic rand_master(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 3);
      int r = $urandom_range(0, 9);
      logic [1:0] s = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      logic [31:0] a = $urandom_range(0, 511);
      if ($urandom_range(0, 3) != 0) a = (s == 2) ? (a & ~32'h3) : (s == 1) ? (a & ~32'h1) : a;
      if (gap > 0) begin drop_req(m); repeat (gap) begin @(posedge CLK); #1; end end
      issue(m, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom, 1);
    end
    drop_req(m);
  endtask

  task automatic contend(input int m);
    for (int i = 0; i < 4; i++)
      issue(m, 1'($urandom_range(0, 1)), 2'd2, 1'b0, 32'h40 + 32'(m * 16 + i * 4), $urandom, 1);
    drop_req(m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  initial begin
    int c, guard;
    RST = 1;
    set_master(0, 0, 0, 0, 0, 0, 0);
    set_master(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    chk("reset_ready_lit", {m0_ready, m1_ready}, 0);
    @(posedge CLK); #1; RST = 0;

    // word store then load
    do_txn(0, 1, 2, 0, 32'h100, 32'hDEADBEEF);
    chk("st_word_lat", last_lat[0], 2);
    chk("st_word_err", last_err[0], 0);
    do_txn(0, 0, 2, 0, 32'h100, 0);
    chk("ld_word_rdata", last_rdata[0], 32'hDEADBEEF);
    chk("ld_word_lat", last_lat[0], 2);

    // byte read-modify-write
    do_txn(0, 1, 2, 0, 32'h100, 32'h11223344);
    do_txn(0, 1, 0, 0, 32'h102, 32'h000000AA);
    chk("rmw_lat", last_lat[0], 3);
    chk("rmw_word", mem[64], 32'h11AA3344);
    chk("rmw_re_cycles", re_cnt, 1);
    chk("rmw_we_cycles", we_cnt, 1);

    // signed / unsigned extraction
    do_txn(1, 1, 2, 0, 32'h104, 32'h80FF7F01);
    do_txn(0, 0, 0, 0, 32'h107, 0);
    chk("ld_b3_signed", last_rdata[0], 32'hFFFFFF80);
    do_txn(1, 0, 0, 1, 32'h107, 0);
    chk("ld_b3_unsigned", last_rdata[1], 32'h00000080);
    do_txn(0, 0, 1, 0, 32'h106, 0);
    chk("ld_h2_signed", last_rdata[0], 32'hFFFF80FF);

    // misaligned
    do_txn(0, 0, 1, 0, 32'h103, 0);
    chk("mis_lat", last_lat[0], 1);
    chk("mis_err", last_err[0], 1);
    chk("mis_rdata", last_rdata[0], 0);
    chk("mis_mem_cycles", re_cnt + we_cnt, 0);

    // reset during the merge write
    do_txn(0, 1, 2, 0, 32'h120, 32'h55667788);
    c = done_cnt[0];
    issue(0, 1, 0, 0, 32'h121, 32'h000000EE, 0);
    guard = 0;
    do begin @(negedge CLK); guard++; end while (!mem_we && guard < 10);
    chk("rst_merge_reached", mem_we, 1);
    #2 RST = 1;
    #1 chk("rst_we_async", mem_we, 0);
    @(posedge CLK); @(posedge CLK); #1 RST = 0;
    chk("rst_no_ack", done_cnt[0], c);
    chk("rst_word_kept", mem[72], 32'h55667788);
    do_txn(0, 1, 0, 0, 32'h121, 32'h000000EE);
    chk("post_rst_lat", last_lat[0], 3);
    chk("post_rst_word", mem[72], 32'h5566EE88);

    // contention
    @(posedge CLK); #1 RST = 1;
    @(posedge CLK); #1 RST = 0;
    grants.delete();
    fork
      contend(0);
      contend(1);
    join
    repeat (6) @(posedge CLK); #1;
    chk("contend_grants", grants.size(), 8);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef DMEM_ACCESS_CTRL_RR_EN
      chk("contend_order", grants[i], i % 2);
`else
      chk("contend_order", grants[i], 0);
`endif
    end

    // randomized traffic from both masters
    fork
      rand_master(0, 60);
      rand_master(1, 60);
    join
    repeat (8) @(posedge CLK); #1;
    for (int i = 0; i < 128; i++) chk("mem_final", mem[i], exp_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
